instr_sequencer: RTL

Multi-cycle control sequencer for the Jac1-8 core. It fetches 16-bit instructions from program memory through a valid handshake and holds the current instruction in an instruction register feeding the decoder. It converts the decoder's level enables into single-cycle register-file, status-register and PC strobes, one instruction at a time. It sits between program memory, the decoder, the register file/status register and the PC counter, and provides run/halt control, a fetch timeout and a retired-instruction counter.

---
 rtl/jac_pkg.sv | 25 ++
 rtl/instr_sequencer_fetch_timer.sv | 39 +++
 rtl/instr_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/jac_pkg.sv
// Shared Jac1-8 definitions: instruction geometry, sequencer state encoding and opcode constants.
package jac_pkg;

   localparam int PROGRAM_DataWidth = 16;
   localparam int NumOpCodeBits     = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4
   } seq_state_t;

   typedef logic [NumOpCodeBits-1:0]     opcode_t;
   typedef logic [PROGRAM_DataWidth-1:0] instr_t;

   localparam opcode_t HaltOpcode = 5'b1_1111;
   localparam instr_t  NopInstr   = '0;

   function automatic opcode_t get_opcode(input instr_t instr);
      return instr[PROGRAM_DataWidth-1 -: NumOpCodeBits];
   endfunction

endpackage

// File: rtl/instr_sequencer_fetch_timer.sv
// FETCH wait counter: counts cycles without valid data; expired fires combinationally on the
// last permitted empty cycle so the FSM can leave FETCH on that same edge.
module fetch_timer
   import jac_pkg::*;
#(
   parameter int FetchTimeout = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CntW = $clog2(FetchTimeout + 1);
   localparam logic [CntW-1:0] LastWait = CntW'(FetchTimeout - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = count_en && (cnt_q == LastWait);

endmodule

// File: rtl/instr_sequencer.sv
// Jac1-8 multi-cycle sequencer: FETCH/DECODE/EXEC/WB with run/halt, fetch timeout and retire count.
// Optional single-step mode (step_req/step_ack) is built when SEQ_SINGLE_STEP_EN is defined.
module instr_sequencer
   import jac_pkg::*;
#(
   parameter int FetchTimeout = 15,
   parameter int RetireWidth  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   input  logic                         halt_req,
   output logic                         prog_req,
   input  logic [PROGRAM_DataWidth-1:0] prog_data,
   input  logic                         prog_valid,
   output logic [PROGRAM_DataWidth-1:0] ir,
   input  logic                         dec_wr_en,
   input  logic                         dec_stat_wr_en,
   input  logic                         dec_cnt_wr_en,
   output logic                         reg_wr_en,
   output logic                         stat_wr_en,
   output logic                         pc_load,
   output logic                         pc_inc,
   output logic [2:0]                   state,
   output logic                         halted,
   output logic                         fetch_err,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                         step_req,
   output logic                         step_ack,
`endif
   output logic [RetireWidth-1:0]       retired
);

   seq_state_t             state_q, state_d;
   instr_t                 ir_q, ir_d;
   logic [RetireWidth-1:0] retired_q, retired_d;
   logic                   fetch_err_q, fetch_err_d;
   logic                   halt_pend_q, halt_pend_d;
   logic                   timer_expired;
   logic                   timer_clear;
   logic                   timer_count;
   logic                   step_start;
   logic                   step_active;

   assign timer_count = (state_q == ST_FETCH) && !prog_valid;
   assign timer_clear = (state_q != ST_FETCH) || prog_valid;

   fetch_timer #(
      .FetchTimeout(FetchTimeout)
   ) u_fetch_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .count_en(timer_count),
      .expired (timer_expired)
   );

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q, step_d;
   logic step_ack_q, step_ack_d;

   // step_q marks an instruction launched by step_req; it forces a return to IDLE after WB
   always_comb begin
      step_d     = step_q;
      step_ack_d = 1'b0;
      if (state_q == ST_IDLE) begin
         if (!fetch_err_q && !run && step_req) begin
            step_d = 1'b1;
         end
      end else if (state_d == ST_IDLE) begin
         step_ack_d = step_q;
         step_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q     <= 1'b0;
         step_ack_q <= 1'b0;
      end else begin
         step_q     <= step_d;
         step_ack_q <= step_ack_d;
      end
   end

   assign step_start  = step_req;
   assign step_active = step_q;
   assign step_ack    = step_ack_q;
`else
   assign step_start  = 1'b0;
   assign step_active = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!fetch_err_q && (run || step_start)) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // valid data beats the timeout when both land on the same cycle
            if (prog_valid) begin
               state_d = ST_DECODE;
            end else if (timer_expired) begin
               state_d = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (get_opcode(ir_q) == HaltOpcode) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_WB;
         ST_WB: begin
            if (halt_pend_q || halt_req || step_active) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      prog_req   = 1'b0;
      halted     = 1'b0;
      reg_wr_en  = 1'b0;
      stat_wr_en = 1'b0;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      case (state_q)
         ST_IDLE:  halted   = 1'b1;
         ST_FETCH: prog_req = 1'b1;
         ST_EXEC:  stat_wr_en = dec_stat_wr_en && !reset;
         ST_WB: begin
            reg_wr_en = dec_wr_en && !reset;
            pc_load   = dec_cnt_wr_en && !reset;
            pc_inc    = !dec_cnt_wr_en && !reset;
         end
         default: ;
      endcase
   end

   always_comb begin
      ir_d        = ir_q;
      retired_d   = retired_q;
      fetch_err_d = fetch_err_q;
      halt_pend_d = halt_pend_q;
      if (state_q == ST_FETCH) begin
         if (prog_valid) begin
            ir_d = prog_data;
         end else if (timer_expired) begin
            fetch_err_d = 1'b1;
         end
      end
      if (state_q == ST_WB) begin
         retired_d = retired_q + RetireWidth'(1);
      end
      if (state_d == ST_IDLE) begin
         halt_pend_d = 1'b0;
      end else if ((state_q != ST_IDLE) && halt_req) begin
         halt_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q        <= NopInstr;
         retired_q   <= '0;
         fetch_err_q <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         ir_q        <= ir_d;
         retired_q   <= retired_d;
         fetch_err_q <= fetch_err_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   assign ir        = ir_q;
   assign retired   = retired_q;
   assign fetch_err = fetch_err_q;
   assign state     = state_q;

endmodule
